// File: rtl/conv_bin_relu_stream_if.sv
// Pixel stream bundle for conv_bin_relu_stream: raster input with valid,
// result output with valid. No back-pressure in either direction.
interface conv_bin_relu_stream_if #(
  parameter int unsigned DW = 32
) ();
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 dout_valid;
  logic signed [DW-1:0] dout;

  modport master (
    output din_valid,
    output din,
    input  dout_valid,
    input  dout
  );

  modport slave (
    input  din_valid,
    input  din,
    output dout_valid,
    output dout
  );
endinterface

// File: rtl/conv_bin_relu_stream.sv
// KxK binary-weight convolution over a raster pixel stream with line buffers,
// a two-stage MAC/saturate pipeline and optional ReLU; two run-time geometries.
module conv_bin_relu_stream #(
  parameter int unsigned DW = 32,
  parameter int unsigned K  = 5,
  parameter int unsigned W0 = 28,
  parameter int unsigned H0 = 28,
  parameter int unsigned W1 = 12,
  parameter int unsigned H1 = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   relu_en,
  input  logic                   weight_en,
  input  logic                   weight,
  conv_bin_relu_stream_if.slave  strm,
  output logic                   busy,
  output logic                   done
);
  localparam int unsigned AW   = DW + $clog2(K * K);
  localparam int unsigned NT   = K * K;
  localparam int unsigned WMax = (W0 > W1) ? W0 : W1;
  localparam int unsigned HMax = (H0 > H1) ? H0 : H1;
  localparam int unsigned CW   = $clog2(WMax);
  localparam int unsigned RW   = $clog2(HMax);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q;
  logic [NT-1:0]        wreg_q;
  logic                 mode_q;
  logic                 relu_q;
  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic                 win_v_q;
  logic                 s1_v_q;
  logic signed [DW-1:0] lb_q  [K-1][WMax];
  logic signed [DW-1:0] win_q [K][K];
  logic signed [AW-1:0] psum_d [K];
  logic signed [AW-1:0] psum_q [K];
  logic signed [AW-1:0] total;
  logic signed [DW-1:0] res;
  logic                 accept;
  logic [CW-1:0]        col_last;
  logic [RW-1:0]        row_last;

  assign accept   = (state_q == StRun) && strm.din_valid;
  assign col_last = mode_q ? CW'(W1 - 1) : CW'(W0 - 1);
  assign row_last = mode_q ? RW'(H1 - 1) : RW'(H0 - 1);

  // lb_q[0] holds the oldest buffered row; window row 0 is the top row.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K - 2; j++) begin
        lb_q[j][col_q] <= lb_q[j+1][col_q];
      end
      lb_q[K-2][col_q] <= strm.din;
      for (int j = 0; j < K - 1; j++) begin
        win_q[j][K-1] <= lb_q[j][col_q];
      end
      win_q[K-1][K-1] <= strm.din;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
    end
    psum_q <= psum_d;
  end

  // Oldest loaded weight bit sits at the MSB and maps to tap (0,0).
  always_comb begin
    for (int r = 0; r < K; r++) begin
      psum_d[r] = '0;
      for (int c = 0; c < K; c++) begin
        if (wreg_q[NT-1-(r*K+c)]) psum_d[r] = psum_d[r] + AW'(win_q[r][c]);
        else                      psum_d[r] = psum_d[r] - AW'(win_q[r][c]);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int r = 0; r < K; r++) begin
      total = total + psum_q[r];
    end
    if (total[AW-1:DW-1] == '0 || total[AW-1:DW-1] == '1) begin
      res = total[DW-1:0];
    end else if (total[AW-1]) begin
      res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res = {1'b0, {(DW-1){1'b1}}};
    end
    if (relu_q && res[DW-1]) res = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= StIdle;
      wreg_q          <= '0;
      mode_q          <= 1'b0;
      relu_q          <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      win_v_q         <= 1'b0;
      s1_v_q          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      strm.dout_valid <= 1'b0;
      strm.dout       <= '0;
    end else begin
      done            <= 1'b0;
      win_v_q         <= 1'b0;
      s1_v_q          <= win_v_q;
      strm.dout_valid <= s1_v_q;
      strm.dout       <= s1_v_q ? res : '0;
      case (state_q)
        StIdle: begin
          if (weight_en) wreg_q <= {wreg_q[NT-2:0], weight};
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            mode_q  <= mode;
            relu_q  <= relu_en;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        StRun: begin
          if (strm.din_valid) begin
            win_v_q <= (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
            if (col_q == col_last) begin
              col_q <= '0;
              if (row_q == row_last) begin
                row_q   <= '0;
                state_q <= StDrain;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        StDrain: begin
          // Last result leaves stage 1 now; done lines up with its dout_valid.
          if (s1_v_q && !win_v_q) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_bin_relu_stream.sv
// Randomised bench for conv_bin_relu_stream: a reference convolution model feeds
// a timestamped scoreboard queue that a negedge monitor drains.
module tb_conv_bin_relu_stream;
  localparam int K = 5;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic relu_en = 1'b0;
  logic weight_en = 1'b0;
  logic weight = 1'b0;
  logic busy;
  logic done;

  conv_bin_relu_stream_if #(.DW(32)) strm ();

  conv_bin_relu_stream dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .mode      (mode),
    .relu_en   (relu_en),
    .weight_en (weight_en),
    .weight    (weight),
    .strm      (strm),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   hist[$];
  int   pix[28][28];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Weight shift register model: the last K*K bits, oldest first.
  task automatic clear_weights_model();
    hist.delete();
    for (int i = 0; i < K * K; i++) hist.push_back(1'b0);
  endtask

  function automatic int ref_out(input int r, input int c, input bit relu);
    longint s = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        longint p = longint'(pix[r-K+1+i][c-K+1+j]);
        s += hist[i*K+j] ? p : -p;
      end
    end
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic load_weights(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      weight_en = 1'b1;
      weight    = bits[i];
      hist.push_back(bits[i]);
      if (hist.size() > K * K) void'(hist.pop_front());
      @(posedge clk); #1;
    end
    weight_en = 1'b0;
  endtask

  task automatic load_uniform(input bit b);
    logic [63:0] v;
    v = b ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    load_weights(v, K * K);
  endtask

  // kind: 0 constant, 1 raster index, 2 full-range random, 3 small signed random
  task automatic run_frame(input bit md, input bit relu, input int kind, input int cval,
                           input int bubble_pct, input bit poke, input int abort_at);
    int  w;
    int  h;
    int  idx;
    bit  got;
    w = md ? 12 : 28;
    h = md ? 12 : 28;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (kind)
          0:       pix[r][c] = cval;
          1:       pix[r][c] = r * w + c;
          2:       pix[r][c] = int'($urandom);
          default: pix[r][c] = int'($urandom_range(2000)) - 1000;
        endcase
      end
    end
    start   = 1'b1;
    mode    = md;
    relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_run", busy, 1);
    idx = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
          strm.din_valid = 1'b0;
          strm.din       = $urandom;
          @(posedge clk); #1;
        end
        if (idx == abort_at) begin
          strm.din_valid = 1'b0;
          rstn = 1'b0;
          // Results due after the reset edge will never appear.
          while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
          clear_weights_model();
          @(posedge clk); #1;
          rstn = 1'b1;
          check("abort_dout_valid", strm.dout_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          repeat (6) @(posedge clk);
          #1;
          check("abort_queue", q.size(), 0);
          return;
        end
        strm.din_valid = 1'b1;
        strm.din       = pix[r][c];
        if (poke && idx == 40) begin
          start     = 1'b1;
          mode      = ~md;
          weight_en = 1'b1;
          weight    = $urandom;
        end
        if (r >= K - 1 && c >= K - 1) q.push_back('{ref_out(r, c, relu), cyc + 3});
        idx++;
        @(posedge clk); #1;
        start     = 1'b0;
        mode      = md;
        weight_en = 1'b0;
      end
    end
    strm.din_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
    check("queue_empty", q.size(), 0);
  endtask

  // Monitor: pops one expectation per dout_valid and checks value and arrival cycle.
  initial begin
    exp_t e;
    wait (rstn === 1'b1);
    forever begin
      @(negedge clk);
      if (strm.dout_valid) begin
        if (q.size() == 0) begin
          check("unexpected_dout_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("dout", strm.dout, e.val);
          check("latency", cyc, e.cyc);
        end
      end else begin
        check("dout_zero_idle", strm.dout, 0);
      end
      if (done) begin
        check("done_with_last_valid", strm.dout_valid, 1);
        check("done_queue_drained", q.size(), 0);
      end
    end
  end

  initial begin
    logic [63:0] rw;
    strm.din_valid = 1'b0;
    strm.din       = '0;
    clear_weights_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", strm.dout_valid, 0);
    check("rst_dout", strm.dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Three stale zeros ahead of 25 ones: only the last 25 bits should count.
    load_weights({36'h0, 25'h1FF_FFFF, 3'b000}, 28);
    run_frame(1'b0, 1'b1, 0, 1, 0, 1'b0, -1);

    load_uniform(1'b0);
    run_frame(1'b1, 1'b1, 0, 1, 0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 0, 1, 0, 1'b0, -1);

    load_uniform(1'b1);
    run_frame(1'b1, 1'b0, 1, 0, 0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 0, 32'h7FFF_FFFF, 0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 0, int'(32'h8000_0000), 0, 1'b0, -1);

    run_frame(1'b1, 1'b0, 1, 0, 30, 1'b1, -1);

    rw = {$urandom, $urandom};
    load_weights(rw, K * K);
    run_frame(1'b0, 1'($urandom), 3, 0, 20, 1'b0, -1);
    run_frame(1'b1, 1'b0, 2, 0, 10, 1'b0, -1);

    // Abort mid-frame; weights must come back cleared.
    run_frame(1'b1, 1'b0, 1, 0, 0, 1'b0, 70);
    run_frame(1'b1, 1'b0, 0, 1, 0, 1'b0, -1);

    rw = {$urandom, $urandom};
    load_weights(rw, K * K);
    run_frame(1'b0, 1'b1, 3, 0, 25, 1'b1, -1);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
